// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test controller.
// The optional MISR signature is enabled with the SCAN_MISR_EN macro.
package scan_ctrl_pkg;

    localparam int unsigned CHAIN_LEN_DEFAULT = 64;
    localparam logic [31:0] MISR_POLY         = 32'h0040_0007;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD
    } state_t;

    // One step of x^32+x^22+x^2+x+1, shifting towards the MSB.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/scan_misr.sv
// 32-bit MISR compacting each accepted response word (built only with SCAN_MISR_EN).
module scan_misr
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CHAIN_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  logic [WIDTH-1:0] data,
    output logic [31:0]      signature
);

    localparam int unsigned SLICES = (WIDTH + 31) / 32;

    logic [SLICES*32-1:0] padded;
    logic [31:0]          folded;

    // Fold the response into 32 bits; the top slice is zero-padded.
    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = data;
        folded             = '0;
        for (int unsigned k = 0; k < SLICES; k++) begin
            folded = folded ^ padded[k*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (update) begin
            signature <= lfsr_step(signature) ^ folded;
        end
    end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan chain test controller: shift/capture/unload sequencing with response handshake.
// Define SCAN_MISR_EN to build the response signature MISR.
module scan_test_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [CHAIN_LEN-1:0] vec_data,
    input  logic                 flush,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 capture,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 busy,
    input  logic                 sig_clear,
    output logic [31:0]          signature
);

    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] vec_sh;
    logic [CHAIN_LEN-2:0] resp_sh;
    logic [CHAIN_LEN-1:0] resp_nxt;
    logic                 pending;
    logic                 keep_resp;
    logic                 shifting;
    logic                 last_shift;
    logic                 accept;
    logic                 start_unload;

    assign shifting     = (state == SHIFT) || (state == UNLOAD);
    assign last_shift   = (cnt == CW'(CHAIN_LEN - 1));
    assign accept       = vec_valid && vec_ready;
    assign start_unload = (state == IDLE) && !resp_valid && pending && flush && !accept;
    assign resp_nxt     = {scan_out, resp_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end else if (start_unload) begin
                    state_nxt = UNLOAD;
                end
            end
            SHIFT:   if (last_shift) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            UNLOAD:  if (last_shift) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vec_ready = (state == IDLE) && !resp_valid;
        scan_en   = shifting;
        scan_in   = (state == SHIFT) ? vec_sh[0] : 1'b0;
        capture   = (state == CAPTURE);
        busy      = (state != IDLE);
    end

    // keep_resp remembers whether the chain held a captured response when this shift began.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            vec_sh     <= '0;
            resp_sh    <= '0;
            pending    <= 1'b0;
            keep_resp  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            if (shifting) begin
                cnt     <= last_shift ? '0 : cnt + CW'(1);
                resp_sh <= resp_nxt[CHAIN_LEN-1:1];
            end

            if (accept) begin
                vec_sh    <= vec_data;
                keep_resp <= pending;
            end else if (state == SHIFT) begin
                vec_sh <= vec_sh >> 1;
            end

            if (state == CAPTURE) begin
                pending <= 1'b1;
            end else if ((state == UNLOAD) && last_shift) begin
                pending <= 1'b0;
            end

            if (shifting && last_shift && ((state == UNLOAD) || keep_resp)) begin
                resp_valid <= 1'b1;
                resp_data  <= resp_nxt;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef SCAN_MISR_EN
    scan_misr #(
        .WIDTH (CHAIN_LEN)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (sig_clear),
        .update    (resp_valid && resp_ready),
        .data      (resp_data),
        .signature (signature)
    );
`else
    logic unused_sig_clear;
    assign unused_sig_clear = sig_clear;
    assign signature        = '0;
`endif

endmodule

// File: doc/scan_test_ctrl.md
SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, meaning scan chain length in bits; legal range 2..1024.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port vec_valid  input  1  test vector offered.
REQ-005 SHALL have port vec_ready  output  1  controller accepts vector this cycle.
REQ-006 SHALL have port vec_data  input  CHAIN_LEN  vector to load; bit 0 shifted first.
REQ-007 SHALL have port flush  input  1  unload pending response without loading a new vector.
REQ-008 SHALL have port scan_en  output  1  chain in shift mode.
REQ-009 SHALL have port scan_in  output  1  serial data into chain.
REQ-010 SHALL have port scan_out  input  1  serial data from chain.
REQ-011 SHALL have port capture  output  1  one-cycle functional capture enable.
REQ-012 SHALL have port resp_valid  output  1  response word available.
REQ-013 SHALL have port resp_ready  input  1  consumer takes response.
REQ-014 SHALL have port resp_data  output  CHAIN_LEN  unloaded response; bit i = scan_out sampled on shift cycle i.
REQ-015 SHALL have port busy  output  1  state != IDLE.
REQ-016 SHALL have port sig_clear  input  1  clear signature (macro build only).
REQ-017 SHALL have port signature  output  32  MISR signature.

Function
REQ-018 SHALL implement states IDLE, SHIFT, CAPTURE, UNLOAD.
REQ-019 vec_ready SHALL be 1 only in IDLE with resp_valid=0; vector accepted on vec_valid&&vec_ready.
REQ-020 Accept at cycle t SHALL give scan_en=1 on cycles t+1..t+CHAIN_LEN, then CAPTURE at t+CHAIN_LEN+1 with scan_en=0, capture=1, then IDLE.
REQ-021 Shift cycle i (0-based) SHALL drive scan_in=vec_data[i] and sample scan_out into response bit i; a CHAIN_LEN-wide counter of $clog2(CHAIN_LEN+1) bits SHALL terminate the shift.
REQ-022 An internal pending flag SHALL set at each CAPTURE; if pending was set at start of a SHIFT, resp_data/resp_valid SHALL be registered on the cycle after the last shift cycle, else the sampled bits are discarded.
REQ-023 flush in IDLE with pending=1 and resp_valid=0 SHALL enter UNLOAD: CHAIN_LEN cycles scan_en=1, scan_in=0, then resp_valid=1, pending=0, no capture, return to IDLE.
REQ-024 flush with pending=0 SHALL be ignored; vec_valid and flush accepted together: vector wins, flush ignored.
REQ-025 resp_valid SHALL hold with stable resp_data until resp_ready; clears on the handshake cycle.
REQ-026 vec_valid/flush outside accept conditions SHALL have no effect; scan_en and capture SHALL never both be 1.

Reset
REQ-027 rst_n low at any time, including mid-SHIFT/UNLOAD, SHALL force IDLE, pending=0, counter=0, scan_en=0, scan_in=0, capture=0, resp_valid=0, resp_data=0, signature=0.
REQ-028 After release, vec_ready SHALL be 1 and busy 0; partially shifted data is discarded.

Configuration
REQ-029 With SCAN_MISR_EN defined, signature SHALL update on each resp handshake: next = lfsr_step(sig) XOR fold(resp_data), polynomial x^32+x^22+x^2+x+1, fold = XOR of 32-bit slices with MSB slice zero-padded; sig_clear SHALL zero it (priority over update).
REQ-030 Without SCAN_MISR_EN, signature SHALL be constant 0 and sig_clear ignored; no MISR logic.

Structure
REQ-031 Package scan_ctrl_pkg SHALL hold the state enum, MISR polynomial constant (32'h0040_0007) and default CHAIN_LEN.
REQ-032 The MISR SHALL be sub-module scan_misr, instantiated only under SCAN_MISR_EN.

Verification (CHAIN_LEN=8, chain modelled as 8-bit shift register with capture loading ~contents)
REQ-033 After reset, vec 8'hA5 accepted -> scan_en high 8 cycles, capture pulse cycle 9, no resp_valid.
REQ-034 Then vec 8'h3C -> resp_valid with resp_data=8'h5A one cycle after 8th shift.
REQ-035 flush with pending -> 8 shift cycles, scan_in=0, resp_data=8'hC3, no capture; second flush ignored.
REQ-036 resp_ready=0 holding response -> vec_ready stays 0, vec_valid ignored until handshake.
REQ-037 rst_n pulsed at shift cycle 4 -> all outputs 0 immediately, next vector yields no response.
REQ-038 SCAN_MISR_EN: responses 8'h5A then 8'hC3 -> signature matches reference model; sig_clear -> 0.
